exu_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the execute stage. It decides each cycle whether the ID/EX register loads the decoded instruction or a bubble (drives EXU `inst_clear`), and whether the front end stalls or flushes. It detects load-use hazards against the instruction in EX and flushes on EX redirects (taken branch/jump). It also sequences a multi-cycle mul/div unit: it holds the instruction in ID until the result is ready, then releases it into EX.

---
 rtl/exu_hazard_ctrl_if.sv | 39 +++
 rtl/exu_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_exu_hazard_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/exu_hazard_ctrl_if.sv
// Purpose: groups the ID/EX hazard inputs and pipeline control outputs of the execute-stage sequencer.
// Latency: none; this is a wiring bundle only.
// Backpressure: stalls and flushes travel from the controller back to the pipeline side.
interface exu_hazard_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic       id_is_md;
  logic [4:0] ex_rd;
  logic       ex_mem_ren;
  logic       ex_redirect;
  logic       md_done;
  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       inst_clear;
  logic       md_start;
  logic       md_abort;
  logic       md_sel;
  logic       md_error;

  // Pipeline side: presents decode/execute status, receives sequencing controls.
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_is_md,
    output ex_rd, ex_mem_ren, ex_redirect, md_done,
    input  pc_stall, if_id_stall, if_id_flush, inst_clear,
    input  md_start, md_abort, md_sel, md_error
  );

  // Controller side.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_is_md,
    input  ex_rd, ex_mem_ren, ex_redirect, md_done,
    output pc_stall, if_id_stall, if_id_flush, inst_clear,
    output md_start, md_abort, md_sel, md_error
  );
endinterface

// File: rtl/exu_hazard_ctrl.sv
// Purpose: execute-stage sequencer: load-use bubbles, redirect flushes, multi-cycle mul/div hold/release.
// Latency: stall/flush/bubble outputs are combinational in the cycle of the cause; md_sel/md_error are registered.
// Backpressure: holds PC and IF/ID while a load-use hazard resolves or a mul/div is outstanding.
module exu_hazard_ctrl #(
  parameter int unsigned FLUSH_EXTRA   = 0,
  parameter int unsigned MD_MAX_CYCLES = 40
) (
  input logic             clk,
  input logic             rst_n,
  exu_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, FLUSH, MD_WAIT} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_EXTRA);
  localparam logic [7:0] MD_LIMIT   = 8'(MD_MAX_CYCLES);
  // With no extra flush cycles the redirect cycle alone clears the front end.
  localparam state_t     REDIR_STATE = (FLUSH_EXTRA > 0) ? FLUSH : RUN;

  state_t     state, state_nxt;
  logic [2:0] flush_cnt, flush_cnt_nxt;
  logic [7:0] md_cnt, md_cnt_nxt;
  logic       sel_q, sel_nxt;
  logic       err_q, err_nxt;
  logic       stall, flush, clear, start, abort;
  logic       lu;

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  always_comb begin
    lu = hz.ex_mem_ren && (hz.ex_rd != 5'd0) && hz.id_valid &&
         ((hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd)) ||
          (hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd)));
  end

  // State, counters and registered result-select/error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= '0;
      md_cnt    <= '0;
      sel_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      md_cnt    <= md_cnt_nxt;
      sel_q     <= sel_nxt;
      err_q     <= err_nxt;
    end
  end

  // Next-state and control outputs; redirect outranks timeout, md_done, load-use and launch.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    md_cnt_nxt    = md_cnt;
    sel_nxt       = 1'b0;
    err_nxt       = err_q;
    stall         = 1'b0;
    flush         = 1'b0;
    clear         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    case (state)
      RUN: begin
        if (hz.ex_redirect) begin
          flush         = 1'b1;
          clear         = 1'b1;
          state_nxt     = REDIR_STATE;
          flush_cnt_nxt = FLUSH_LOAD;
        end else if (lu) begin
          stall = 1'b1;
          clear = 1'b1;
        end else if (hz.id_valid && hz.id_is_md) begin
          start      = 1'b1;
          stall      = 1'b1;
          clear      = 1'b1;
          md_cnt_nxt = 8'd1;
          state_nxt  = MD_WAIT;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        clear = 1'b1;
        if (hz.ex_redirect) begin
          flush_cnt_nxt = FLUSH_LOAD;
          state_nxt     = REDIR_STATE;
        end else if (flush_cnt <= 3'd1) begin
          flush_cnt_nxt = '0;
          state_nxt     = RUN;
        end else begin
          flush_cnt_nxt = flush_cnt - 3'd1;
        end
      end
      MD_WAIT: begin
        if (hz.ex_redirect) begin
          // Older instruction in EX redirected: the mul/div in ID is wrong-path.
          abort         = 1'b1;
          flush         = 1'b1;
          clear         = 1'b1;
          md_cnt_nxt    = '0;
          flush_cnt_nxt = FLUSH_LOAD;
          state_nxt     = REDIR_STATE;
        end else if ((md_cnt == MD_LIMIT) && !hz.md_done) begin
          // Unit hung: drop the instruction as a bubble and flag it.
          abort      = 1'b1;
          clear      = 1'b1;
          err_nxt    = 1'b1;
          md_cnt_nxt = '0;
          state_nxt  = RUN;
        end else if (hz.md_done) begin
          // Release the held instruction into EX with the mul/div result selected.
          sel_nxt    = 1'b1;
          md_cnt_nxt = '0;
          state_nxt  = RUN;
        end else begin
          stall      = 1'b1;
          clear      = 1'b1;
          md_cnt_nxt = md_cnt + 8'd1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Drive the interface; both stall outputs share one source so they never diverge.
  always_comb begin
    hz.pc_stall    = stall;
    hz.if_id_stall = stall;
    hz.if_id_flush = flush;
    hz.inst_clear  = clear;
    hz.md_start    = start;
    hz.md_abort    = abort;
    hz.md_sel      = sel_q;
    hz.md_error    = err_q;
  end

endmodule

// File: tb/tb_exu_hazard_ctrl.sv
// Purpose: scoreboard bench for exu_hazard_ctrl, two configurations driven with identical stimulus.
// Latency: expected outputs are queued at stimulus time and compared at the following negedge.
// Backpressure: none; the monitor consumes one expected vector per DUT per cycle.
module tb_exu_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs1_used, id_rs2_used, id_is_md;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_mem_ren, ex_redirect, md_done;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // Reference state per configuration: 0 = FLUSH_EXTRA 0 / limit 8, 1 = FLUSH_EXTRA 2 / limit 40.
  int flush_left[2];
  bit busy[2];
  int age[2];
  bit sel[2];
  bit err[2];

  exu_hazard_ctrl_if if0 ();
  exu_hazard_ctrl_if if1 ();

  exu_hazard_ctrl #(.FLUSH_EXTRA(0), .MD_MAX_CYCLES(8)) dut0 (.clk(clk), .rst_n(rst_n), .hz(if0.slave));
  exu_hazard_ctrl #(.FLUSH_EXTRA(2)) dut1 (.clk(clk), .rst_n(rst_n), .hz(if1.slave));

  assign if0.id_valid = id_valid;       assign if1.id_valid = id_valid;
  assign if0.id_rs1 = id_rs1;           assign if1.id_rs1 = id_rs1;
  assign if0.id_rs2 = id_rs2;           assign if1.id_rs2 = id_rs2;
  assign if0.id_rs1_used = id_rs1_used; assign if1.id_rs1_used = id_rs1_used;
  assign if0.id_rs2_used = id_rs2_used; assign if1.id_rs2_used = id_rs2_used;
  assign if0.id_is_md = id_is_md;       assign if1.id_is_md = id_is_md;
  assign if0.ex_rd = ex_rd;             assign if1.ex_rd = ex_rd;
  assign if0.ex_mem_ren = ex_mem_ren;   assign if1.ex_mem_ren = ex_mem_ren;
  assign if0.ex_redirect = ex_redirect; assign if1.ex_redirect = ex_redirect;
  assign if0.md_done = md_done;         assign if1.md_done = md_done;

  always #5 clk = ~clk;

  // Expected outputs for this cycle as {pc_stall, if_id_stall, if_id_flush, inst_clear, md_start, md_abort, md_sel, md_error},
  // then advance the reference to the state after the coming posedge.
  task automatic model_eval(input int d, output logic [7:0] e);
    int  ext = (d == 0) ? 0 : 2;
    int  lim = (d == 0) ? 8 : 40;
    bit  stl = 0, fl = 0, clr = 0, st = 0, ab = 0, sel_n = 0, err_set = 0;
    bit  hazard;
    hazard = ex_mem_ren && (ex_rd != 0) && id_valid &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    if (flush_left[d] > 0) begin
      fl = 1; clr = 1;
      flush_left[d] = ex_redirect ? ext : flush_left[d] - 1;
    end else if (busy[d]) begin
      if (ex_redirect) begin
        ab = 1; fl = 1; clr = 1; busy[d] = 0; flush_left[d] = ext;
      end else if (age[d] == lim && !md_done) begin
        ab = 1; clr = 1; err_set = 1; busy[d] = 0;
      end else if (md_done) begin
        sel_n = 1; busy[d] = 0;
      end else begin
        stl = 1; clr = 1; age[d] = age[d] + 1;
      end
    end else if (ex_redirect) begin
      fl = 1; clr = 1; flush_left[d] = ext;
    end else if (hazard) begin
      stl = 1; clr = 1;
    end else if (id_valid && id_is_md) begin
      st = 1; stl = 1; clr = 1; busy[d] = 1; age[d] = 1;
    end
    e = {stl, stl, fl, clr, st, ab, sel[d], err[d]};
    sel[d] = sel_n;
    err[d] = err[d] | err_set;
    if (!rst_n) begin
      flush_left[d] = 0; busy[d] = 0; age[d] = 0; sel[d] = 0; err[d] = 0;
    end
  endtask

  task automatic idle();
    rst_n = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_is_md = 0; ex_rd = 0; ex_mem_ren = 0; ex_redirect = 0; md_done = 0;
  endtask

  // Inputs are already applied; queue the expectation and move to the next cycle.
  task automatic step();
    logic [7:0] e;
    model_eval(0, e); q0.push_back(e);
    model_eval(1, e); q1.push_back(e);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: every cycle each DUT presents a full output vector; compare against the queued expectation.
  always @(negedge clk) begin
    logic [7:0] got, exp;
    if (q0.size() > 0) begin
      exp = q0.pop_front();
      got = {if0.pc_stall, if0.if_id_stall, if0.if_id_flush, if0.inst_clear,
             if0.md_start, if0.md_abort, if0.md_sel, if0.md_error};
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL dut0_outputs cycle %0d: got %b expected %b", cyc, got, exp);
    end
    if (q1.size() > 0) begin
      exp = q1.pop_front();
      got = {if1.pc_stall, if1.if_id_stall, if1.if_id_flush, if1.inst_clear,
             if1.md_start, if1.md_abort, if1.md_sel, if1.md_error};
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL dut1_outputs cycle %0d: got %b expected %b", cyc, got, exp);
    end
  end

  initial begin
    idle();
    rst_n = 0;
    for (int d = 0; d < 2; d++) begin
      flush_left[d] = 0; busy[d] = 0; age[d] = 0; sel[d] = 0; err[d] = 0;
    end
    @(posedge clk); @(posedge clk); #1;

    // Reset state, inputs idle.
    idle(); steps(2);

    // Load-use on x5, then the same pattern against x0.
    ex_mem_ren = 1; ex_rd = 5; id_valid = 1; id_rs1 = 5; id_rs1_used = 1; step();
    ex_mem_ren = 0; step();
    ex_mem_ren = 1; ex_rd = 0; id_rs1 = 0; step();
    ex_mem_ren = 1; ex_rd = 7; id_rs1 = 1; id_rs2 = 7; id_rs2_used = 1; step();
    idle(); step();

    // Redirect pulse: one flush cycle on dut0, three on dut1.
    ex_redirect = 1; step();
    idle(); steps(4);

    // Mul/div launch, four held cycles, done, then result select for one cycle.
    id_valid = 1; id_is_md = 1; step();
    steps(4);
    md_done = 1; step();
    idle(); steps(3);

    // Abort by redirect one cycle after launch; later md_done is ignored.
    id_valid = 1; id_is_md = 1; step();
    idle(); ex_redirect = 1; step();
    idle(); step(); md_done = 1; step(); idle(); steps(3);

    // Timeout: dut0 after 8 cycles, dut1 after 40; error stays sticky.
    id_valid = 1; id_is_md = 1; step();
    idle(); steps(45);

    // Load-use together with redirect: flush only.
    ex_mem_ren = 1; ex_rd = 5; id_valid = 1; id_rs1 = 5; id_rs1_used = 1; ex_redirect = 1; step();
    idle(); steps(3);

    // Reset while waiting on mul/div clears everything including the error flag.
    id_valid = 1; id_is_md = 1; step();
    idle(); step();
    rst_n = 0; step();
    idle(); steps(2);

    // Redirect with md_done in the same cycle: redirect wins.
    id_valid = 1; id_is_md = 1; step();
    idle(); ex_redirect = 1; md_done = 1; step();
    idle(); steps(3);

    // Randomized traffic over a small register range so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(199) != 0);
      id_valid    = ($urandom_range(9) < 7);
      id_rs1      = 5'($urandom_range(7));
      id_rs2      = 5'($urandom_range(7));
      id_rs1_used = 1'($urandom_range(1));
      id_rs2_used = 1'($urandom_range(1));
      id_is_md    = ($urandom_range(99) < 15);
      ex_rd       = 5'($urandom_range(7));
      ex_mem_ren  = ($urandom_range(9) < 3);
      ex_redirect = ($urandom_range(99) < 6);
      md_done     = ($urandom_range(99) < 12);
      step();
    end

    idle(); steps(2);
    @(negedge clk); #1;
    n_total++;
    if (q0.size() == 0 && q1.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d/%0d left required 0/0", q0.size(), q1.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
